// File: rtl/tiny_rv_pkg.sv
// Shared types and constants for the tiny_rv core.
// Holds the RV32I major opcodes, the instruction width and the fetch buffer entry type.
package tiny_rv_pkg;

  localparam logic [6:0] RV_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] RV_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] RV_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] RV_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] RV_OPC_OP     = 7'b0110011;
  localparam logic [6:0] RV_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] RV_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] RV_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] RV_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] RV_OPC_SYSTEM = 7'b1110011;

  localparam int unsigned RV_INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } tiny_rv_fetch_entry_t;

  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } fetch_state_e;

  // JALR-style target: bit 0 is always cleared.
  function automatic logic [31:0] rv_jalr_target(input logic [31:0] addr);
    return {addr[31:1], 1'b0};
  endfunction

  // A cleared-bit-0 target with bit 1 set cannot be fetched as a word.
  function automatic logic rv_target_misaligned(input logic [31:0] target);
    return target[1];
  endfunction

endpackage

// File: rtl/tiny_rv_fifo.sv
// Synchronous FIFO of fetch entries with a flush that overrides pop and stored contents.
// A push in the same cycle as a flush lands as the sole entry of the emptied buffer.
module tiny_rv_fifo
  import tiny_rv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  tiny_rv_fetch_entry_t     push_data,
  input  logic                     pop,
  output tiny_rv_fetch_entry_t     head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level_next
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  tiny_rv_fetch_entry_t mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] level_q, level_d;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  assign full  = (level_q == CW'(DEPTH));
  assign valid = (level_q != '0);
  assign wr_en = push && (flush || !full);
  assign rd_en = pop && valid && !flush;
  assign head  = mem_q[rd_ptr_q];
  assign level_next = level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      level_d  = CW'(wr_en);
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      level_d = level_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));

endmodule

// File: rtl/tiny_rv_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests under a credit
// limit, buffers responses and handles branch redirects, misaligned targets and bus errors.
module tiny_rv_fetch
  import tiny_rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        br_taken,
  input  logic [31:0] br_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_next_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 2;
  localparam logic [31:0] PC_STEP = 32'(RV_INSTR_BYTES);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic         req_valid_q, req_valid_d;

  logic                 accept;
  logic                 rsp_live;
  logic                 rsp_drop;
  logic [31:0]          rsp_pc;
  logic [31:0]          br_target;
  logic                 flush;
  logic                 push;
  tiny_rv_fetch_entry_t push_entry;
  logic                 pop;
  tiny_rv_fetch_entry_t head;
  logic                 head_valid;
  logic [CW-1:0]        level_next;
  logic [SW-1:0]        credit_used;

  assign accept    = req_valid_q && imem_req_ready;
  assign rsp_drop  = imem_rsp_valid && (discard_q != '0);
  assign rsp_live  = imem_rsp_valid && (discard_q == '0);
  assign br_target = rv_jalr_target(br_addr);
  assign pop       = head_valid && out_ready;

  // Live requests are consecutive words ending just below fetch_pc, so the oldest one
  // (the one answering now) sits outstanding words back.
  assign rsp_pc = fetch_pc_q - (32'(outstanding_q) << 2);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = accept ? fetch_pc_q + PC_STEP : fetch_pc_q;
    outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_live);
    discard_d     = discard_q - CW'(rsp_drop);
    flush         = 1'b0;
    push          = rsp_live;
    push_entry    = '{pc: rsp_pc, instr: imem_rsp_data, fault: imem_rsp_err};

    if (rsp_live && imem_rsp_err) begin
      state_d       = StHalt;
      outstanding_d = '0;
      discard_d     = outstanding_q - CW'(1) + CW'(accept);
    end

    // A redirect wins over any response, error or pop in the same cycle.
    if (br_taken) begin
      flush         = 1'b1;
      fetch_pc_d    = br_target;
      outstanding_d = '0;
      discard_d     = outstanding_q + discard_q + CW'(accept) - CW'(imem_rsp_valid);
      if (rv_target_misaligned(br_target)) begin
        state_d    = StHalt;
        push       = 1'b1;
        push_entry = '{pc: br_target, instr: 32'h0, fault: 1'b1};
      end else begin
        state_d = StRun;
        push    = 1'b0;
      end
    end
  end

  // Credit is evaluated on next-state counts so the registered valid equals the rule
  // applied to the registered counts in the following cycle.
  assign credit_used = SW'(outstanding_d) + SW'(discard_d) + SW'(level_next);
  assign req_valid_d = (state_d == StRun) && (credit_used < SW'(FIFO_DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StRun;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      req_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      req_valid_q   <= req_valid_d;
    end
  end

  tiny_rv_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .flush      (flush),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head       (head),
    .valid      (head_valid),
    .level_next (level_next)
  );

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign out_valid      = head_valid;
  assign out_pc         = head.pc;
  assign out_next_pc    = head.pc + PC_STEP;
  assign out_instr      = head.instr;
  assign out_fault      = head_valid && head.fault;

endmodule

// File: tb/tb_tiny_rv_fetch.sv
// Randomised scoreboard bench for tiny_rv_fetch with an in-order memory model and an
// epoch-based model of which fetched words must reach decode.
module tb_tiny_rv_fetch;
  import tiny_rv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_next_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_out_valid;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_next_pc;
  logic [31:0] w_out_instr;
  logic        w_out_fault;

  always #5 clk = ~clk;

  tiny_rv_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .br_taken(br_taken), .br_addr(br_addr),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_next_pc(out_next_pc), .out_instr(out_instr), .out_fault(out_fault)
  );

  tiny_rv_fetch #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(4)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .br_taken(1'b0), .br_addr(32'h0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .imem_rsp_err(1'b0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_pc(w_out_pc),
    .out_next_pc(w_out_next_pc), .out_instr(w_out_instr), .out_fault(w_out_fault)
  );

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } req_t;

  req_t                 pend[$];
  tiny_rv_fetch_entry_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int epoch = 0;
  int last_due = -1;
  int lat = 1;
  int accepts = 0;
  int pops = 0;
  int first_acc = -1;
  int first_ov = -1;
  int w_n = 0;
  logic        m_halt = 1'b0;
  logic [31:0] m_fetch_pc = RST_PC;
  logic        rdy_rand = 1'b0;
  logic        lat_rand = 1'b0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic        chk_redir = 1'b0;
  logic        redir_mis = 1'b0;
  logic [31:0] redir_tgt = 32'h0;
  logic        w_acc = 1'b0;
  logic [31:0] w_acc_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]} ^ 32'h0F0F_1234;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops the scoreboard whenever decode takes the head.
  always @(negedge clk) begin
    tiny_rv_fetch_entry_t e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual_pc=%h required=no_output", out_pc);
      end else begin
        e = sb.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", out_instr, e.instr);
        chk("out_fault", {31'h0, out_fault}, {31'h0, e.fault});
        chk("out_next_pc", out_next_pc, e.pc + 32'd4);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    br_taken = 1'b0; br_addr = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; imem_rsp_err = 1'b0; out_ready = 1'b0;
    w_rsp_valid = 1'b0; w_rsp_data = '0;
    #1;
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_fault", {31'h0, out_fault}, 32'h0);
    pend.delete(); sb.delete();
    epoch++; last_due = -1; m_halt = 1'b0; m_fetch_pc = RST_PC;
    chk_redir = 1'b0; w_acc = 1'b0; err_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick(input logic br, input logic [31:0] ba, input logic ordy);
    logic rv, ov, rdy, rsp, err, halt0, wov;
    logic [31:0] ra, tgt, wexp;
    int cur_ep, due;
    req_t h;
    @(negedge clk);
    rv = imem_req_valid; ra = imem_req_addr; ov = out_valid;
    cur_ep = epoch; halt0 = m_halt;
    if (chk_redir) begin
      chk("redirect_addr", ra, redir_tgt);
      chk("redirect_out_valid", {31'h0, ov}, {31'h0, redir_mis});
      chk_redir = 1'b0;
    end
    if (halt0) chk("halt_quiet", {31'h0, rv}, 32'h0);
    rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_req_ready = rdy;
    imem_rsp_valid = rsp;
    br_taken = br;
    br_addr = ba;
    out_ready = br ? 1'b0 : ordy;
    if (rsp) begin
      h = pend.pop_front();
      err = err_en && (h.addr == err_addr);
      imem_rsp_data = mem_word(h.addr);
      imem_rsp_err = err;
      if (!br && h.ep == cur_ep) begin
        sb.push_back('{pc: h.addr, instr: mem_word(h.addr), fault: err});
        if (err) begin
          epoch++;
          m_halt = 1'b1;
        end
      end
    end else begin
      imem_rsp_data = $urandom;
      imem_rsp_err = 1'b0;
    end
    if (ov && out_ready) pops++;
    if (ov && first_ov < 0) first_ov = cyc;
    if (rv && rdy) begin
      accepts++;
      if (first_acc < 0) first_acc = cyc;
      if (!halt0) chk("req_addr", ra, m_fetch_pc);
      m_fetch_pc = m_fetch_pc + 32'd4;
      due = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: ra, ep: cur_ep, due: due});
    end
    if (br) begin
      sb.delete();
      epoch++;
      tgt = {ba[31:1], 1'b0};
      m_fetch_pc = tgt;
      m_halt = tgt[1];
      if (tgt[1]) sb.push_back('{pc: tgt, instr: 32'h0, fault: 1'b1});
      chk_redir = 1'b1; redir_tgt = tgt; redir_mis = tgt[1];
    end
    // Wrap instance: fixed 1-cycle memory, always ready, checks its first two outputs.
    wov = w_out_valid;
    if (wov && w_n < 2) begin
      wexp = (w_n == 0) ? 32'hFFFF_FFFC : 32'h0000_0000;
      chk("wrap_pc", w_out_pc, wexp);
      chk("wrap_next_pc", w_out_next_pc, wexp + 32'd4);
      chk("wrap_instr", w_out_instr, mem_word(wexp));
      w_n++;
    end
    w_rsp_valid = w_acc;
    w_rsp_data = mem_word(w_acc_addr);
    w_acc = w_req_valid;
    w_acc_addr = w_req_addr;
    cyc++;
  endtask

  initial begin
    int a0, p0, n;
    logic [31:0] ba;
    rst_n = 1'b0;
    do_reset();
    first_acc = -1; first_ov = -1;

    // Straight-line fetch from reset with a 1-cycle memory.
    repeat (30) tick(1'b0, 32'h0, 1'b1);
    chk("first_latency", 32'(first_ov - first_acc), 32'd2);
    p0 = pops;
    repeat (20) tick(1'b0, 32'h0, 1'b1);
    chk("sustained_rate", 32'(pops - p0), 32'd20);

    // Stall decode: requests must stop at the buffer depth.
    tick(1'b1, 32'h0000_0800, 1'b1);
    a0 = accepts;
    repeat (10) tick(1'b0, 32'h0, 1'b0);
    chk("stall_accepts_le4", {31'h0, (accepts - a0) <= 4}, 32'h1);
    chk("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
    repeat (20) tick(1'b0, 32'h0, 1'b1);

    // Redirect with responses in flight.
    lat = 3;
    n = 0;
    while (pend.size() < 2 && n < 10) begin
      tick(1'b0, 32'h0, 1'b1);
      n++;
    end
    chk("inflight_ge2", {31'h0, pend.size() >= 2}, 32'h1);
    tick(1'b1, 32'h0000_2001, 1'b1);
    repeat (20) tick(1'b0, 32'h0, 1'b1);

    // Misaligned redirect halts after one fault entry.
    lat = 1;
    tick(1'b1, 32'h0000_3002, 1'b1);
    a0 = accepts;
    repeat (8) tick(1'b0, 32'h0, 1'b0);
    repeat (5) tick(1'b0, 32'h0, 1'b1);
    chk("halt_no_req", 32'(accepts - a0), 32'd0);

    // Bus error on 0x108 with younger requests in flight.
    lat = 2; err_en = 1'b1; err_addr = 32'h0000_0108;
    tick(1'b1, 32'h0000_0100, 1'b1);
    repeat (12) tick(1'b0, 32'h0, 1'b1);
    a0 = accepts;
    repeat (8) tick(1'b0, 32'h0, 1'b1);
    chk("err_halt_holds", 32'(accepts - a0), 32'd0);
    err_en = 1'b0;
    tick(1'b1, 32'h0000_0040, 1'b1);
    repeat (15) tick(1'b0, 32'h0, 1'b1);

    // PC wrap through a redirect.
    lat = 1;
    tick(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (10) tick(1'b0, 32'h0, 1'b1);

    // Random traffic with a mid-run reset.
    rdy_rand = 1'b1; lat_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      ba = $urandom;
      if ($urandom_range(0, 3) != 0) ba[1] = 1'b0;
      if ($urandom_range(0, 7) == 0) ba[31:8] = 24'hFF_FFFF;
      if (!err_en && $urandom_range(0, 49) == 0) begin
        err_en = 1'b1;
        err_addr = m_fetch_pc - 32'(4 * $urandom_range(0, 3));
      end
      if ($urandom_range(0, 39) == 0) begin
        tick(1'b1, ba, 1'b1);
        err_en = 1'b0;
      end else begin
        tick(1'b0, 32'h0, 1'($urandom_range(0, 3) != 0));
      end
    end

    // Park in HALT and drain everything.
    rdy_rand = 1'b0; lat_rand = 1'b0; err_en = 1'b0;
    tick(1'b1, 32'h0000_5002, 1'b1);
    n = 0;
    while ((pend.size() > 0 || sb.size() > 0) && n < 50) begin
      tick(1'b0, 32'h0, 1'b1);
      n++;
    end
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("progress", {31'h0, pops > 300}, 32'h1);
    chk("wrap_seen", 32'(w_n), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
